// File: rtl/fft_filter_seq.sv
`timescale 1ns/1ps
// Frame sequencer for the FFT -> complex-multiply -> IFFT chain: configures both cores,
// streams one ADC frame in, tracks output bins for the coefficient RAM, and frames the IFFT input.
module fft_filter_seq #(
  parameter int         NFFT_LOG2 = 10,
  parameter int         CMPY_LAT  = 6,
  parameter logic [7:0] CFG_FWD   = 8'h01,
  parameter logic [7:0] CFG_INV   = 8'h00,
  parameter int         TIMEOUT   = 4096
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  input  logic [9:0]           adc_data,
  output logic [7:0]           fwd_cfg_tdata,
  output logic                 fwd_cfg_tvalid,
  input  logic                 fwd_cfg_tready,
  output logic [7:0]           inv_cfg_tdata,
  output logic                 inv_cfg_tvalid,
  input  logic                 inv_cfg_tready,
  output logic [31:0]          fwd_s_tdata,
  output logic                 fwd_s_tvalid,
  input  logic                 fwd_s_tready,
  output logic                 fwd_s_tlast,
  input  logic                 fwd_m_tvalid,
  input  logic                 fwd_m_tlast,
  output logic [NFFT_LOG2-1:0] coef_addr,
  output logic                 inv_s_tvalid,
  output logic                 inv_s_tlast,
  input  logic                 inv_s_tready
);

  localparam int DEPTH  = 1 + CMPY_LAT;
  localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [NFFT_LOG2-1:0] LAST_IDX  = '1;
  localparam logic [NFFT_LOG2-1:0] PEN_IDX   = LAST_IDX - NFFT_LOG2'(1);
  localparam logic [NFFT_LOG2:0]   N_BEATS   = {1'b1, {NFFT_LOG2{1'b0}}};
  localparam logic [WCNT_W-1:0]    WAIT_LAST = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_LOAD,
    S_WAIT_OUT,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t               state_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic                 fwd_cfg_tvalid_q;
  logic                 inv_cfg_tvalid_q;
  logic [7:0]           fwd_cfg_tdata_q;
  logic [7:0]           inv_cfg_tdata_q;
  logic                 fwd_s_tvalid_q;
  logic                 fwd_s_tlast_q;
  logic [NFFT_LOG2-1:0] in_cnt_q;
  logic [NFFT_LOG2-1:0] bin_cnt_q;
  logic [NFFT_LOG2:0]   out_cnt_q;
  logic [NFFT_LOG2:0]   out_cnt_d;
  logic [WCNT_W-1:0]    wait_cnt_q;
  logic [DEPTH-1:0]     pipe_vld_q;
  logic [DEPTH-1:0]     pipe_last_q;

  logic bin_active;
  logic out_beat;
  logic bin_is_last;
  logic in_beat;
  logic frame_err;
  logic prod_lost;
  logic cfg_fwd_ok;
  logic cfg_inv_ok;

  assign bin_active  = (state_q == S_LOAD) || (state_q == S_WAIT_OUT);
  assign out_beat    = bin_active && fwd_m_tvalid;
  assign bin_is_last = (bin_cnt_q == LAST_IDX);
  assign in_beat     = fwd_s_tvalid_q && fwd_s_tready;
  assign frame_err   = out_beat && (fwd_m_tlast != bin_is_last);
  // The multiplier cannot stall, so an unaccepted product is simply lost.
  assign prod_lost   = pipe_vld_q[DEPTH-1] && !inv_s_tready;
  assign cfg_fwd_ok  = !fwd_cfg_tvalid_q || fwd_cfg_tready;
  assign cfg_inv_ok  = !inv_cfg_tvalid_q || inv_cfg_tready;
  assign out_cnt_d   = (out_beat && !out_cnt_q[NFFT_LOG2]) ?
                       out_cnt_q + (NFFT_LOG2+1)'(1) : out_cnt_q;

  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;
  assign fwd_cfg_tdata  = fwd_cfg_tdata_q;
  assign fwd_cfg_tvalid = fwd_cfg_tvalid_q;
  assign inv_cfg_tdata  = inv_cfg_tdata_q;
  assign inv_cfg_tvalid = inv_cfg_tvalid_q;
  assign fwd_s_tdata    = {22'b0, adc_data};
  assign fwd_s_tvalid   = fwd_s_tvalid_q;
  assign fwd_s_tlast    = fwd_s_tlast_q;
  assign coef_addr      = bin_cnt_q;
  assign inv_s_tvalid   = pipe_vld_q[DEPTH-1];
  assign inv_s_tlast    = pipe_last_q[DEPTH-1];

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q          <= S_IDLE;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 1'b0;
      fwd_cfg_tvalid_q <= 1'b0;
      inv_cfg_tvalid_q <= 1'b0;
      fwd_cfg_tdata_q  <= '0;
      inv_cfg_tdata_q  <= '0;
      fwd_s_tvalid_q   <= 1'b0;
      fwd_s_tlast_q    <= 1'b0;
      in_cnt_q         <= '0;
      bin_cnt_q        <= '0;
      out_cnt_q        <= '0;
      wait_cnt_q       <= '0;
    end else begin
      done_q    <= 1'b0;
      out_cnt_q <= out_cnt_d;
      if (out_beat) bin_cnt_q <= bin_cnt_q + NFFT_LOG2'(1);
      if (frame_err || prod_lost) err_q <= 1'b1;

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q          <= S_CFG;
            busy_q           <= 1'b1;
            err_q            <= 1'b0;
            in_cnt_q         <= '0;
            bin_cnt_q        <= '0;
            out_cnt_q        <= '0;
            wait_cnt_q       <= '0;
            fwd_cfg_tvalid_q <= 1'b1;
            inv_cfg_tvalid_q <= 1'b1;
            fwd_cfg_tdata_q  <= CFG_FWD;
            inv_cfg_tdata_q  <= CFG_INV;
          end
        end
        S_CFG: begin
          if (fwd_cfg_tready) fwd_cfg_tvalid_q <= 1'b0;
          if (inv_cfg_tready) inv_cfg_tvalid_q <= 1'b0;
          if (cfg_fwd_ok && cfg_inv_ok) begin
            state_q        <= S_LOAD;
            fwd_s_tvalid_q <= 1'b1;
          end
        end
        S_LOAD: begin
          if (in_beat) begin
            in_cnt_q      <= in_cnt_q + NFFT_LOG2'(1);
            fwd_s_tlast_q <= (in_cnt_q == PEN_IDX);
            if (in_cnt_q == LAST_IDX) begin
              state_q        <= S_WAIT_OUT;
              fwd_s_tvalid_q <= 1'b0;
              fwd_s_tlast_q  <= 1'b0;
              wait_cnt_q     <= '0;
            end
          end
        end
        S_WAIT_OUT: begin
          if (out_cnt_d == N_BEATS) begin
            state_q <= S_DRAIN;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q <= S_DRAIN;
            err_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + WCNT_W'(1);
          end
        end
        S_DRAIN: begin
          if (pipe_vld_q == '0) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Alignment pipe: one RAM-read cycle plus the multiplier latency.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
    end else begin
      pipe_vld_q  <= {pipe_vld_q[DEPTH-2:0], out_beat};
      pipe_last_q <= {pipe_last_q[DEPTH-2:0], out_beat && bin_is_last};
    end
  end

endmodule

// File: tb/tb_fft_filter_seq.sv
`timescale 1ns/1ps
// Directed bench for fft_filter_seq: frame-level model of beats, bins, product timing and errors.
module tb_fft_filter_seq;
  localparam int NL   = 10;
  localparam int N    = 1024;
  localparam int TO   = 4096;
  localparam int MAXC = 32768;

  logic          sys_clk = 1'b0;
  logic          sys_rst, start, busy, done, err;
  logic [9:0]    adc_data;
  logic [7:0]    fwd_cfg_tdata, inv_cfg_tdata;
  logic          fwd_cfg_tvalid, fwd_cfg_tready, inv_cfg_tvalid, inv_cfg_tready;
  logic [31:0]   fwd_s_tdata;
  logic          fwd_s_tvalid, fwd_s_tready, fwd_s_tlast;
  logic          fwd_m_tvalid, fwd_m_tlast;
  logic [NL-1:0] coef_addr;
  logic          inv_s_tvalid, inv_s_tlast, inv_s_tready;

  fft_filter_seq #(.NFFT_LOG2(NL), .CMPY_LAT(6), .CFG_FWD(8'h01), .CFG_INV(8'h00), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .busy(busy), .done(done), .err(err),
    .adc_data(adc_data),
    .fwd_cfg_tdata(fwd_cfg_tdata), .fwd_cfg_tvalid(fwd_cfg_tvalid), .fwd_cfg_tready(fwd_cfg_tready),
    .inv_cfg_tdata(inv_cfg_tdata), .inv_cfg_tvalid(inv_cfg_tvalid), .inv_cfg_tready(inv_cfg_tready),
    .fwd_s_tdata(fwd_s_tdata), .fwd_s_tvalid(fwd_s_tvalid), .fwd_s_tready(fwd_s_tready),
    .fwd_s_tlast(fwd_s_tlast), .fwd_m_tvalid(fwd_m_tvalid), .fwd_m_tlast(fwd_m_tlast),
    .coef_addr(coef_addr), .inv_s_tvalid(inv_s_tvalid), .inv_s_tlast(inv_s_tlast),
    .inv_s_tready(inv_s_tready)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_tot = 0, n_pass = 0;
  bit exp_v [MAXC];
  bit exp_l [MAXC];
  bit chk_on = 1'b0;
  int inv_v_cnt = 0, inv_l_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
  endtask

  // Product stream model: a beat sampled at edge k must appear 7 cycles later.
  always @(negedge sys_clk) begin
    if (chk_on && cyc < MAXC) begin
      chk1("inv_tvalid", inv_s_tvalid, exp_v[cyc]);
      chk1("inv_tlast", inv_s_tlast, exp_l[cyc]);
      if (inv_s_tvalid === 1'b1) inv_v_cnt++;
      if (inv_s_tlast === 1'b1) inv_l_cnt++;
    end
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_reset_vals(input string nm);
    chk1({nm, "_busy"}, busy, 1'b0);
    chk1({nm, "_done"}, done, 1'b0);
    chk1({nm, "_err"}, err, 1'b0);
    chk({nm, "_coef_addr"}, 32'(coef_addr), 32'd0);
    chk1({nm, "_fwd_cfg_tvalid"}, fwd_cfg_tvalid, 1'b0);
    chk1({nm, "_inv_cfg_tvalid"}, inv_cfg_tvalid, 1'b0);
    chk({nm, "_fwd_cfg_tdata"}, 32'(fwd_cfg_tdata), 32'd0);
    chk({nm, "_inv_cfg_tdata"}, 32'(inv_cfg_tdata), 32'd0);
    chk1({nm, "_fwd_s_tvalid"}, fwd_s_tvalid, 1'b0);
    chk1({nm, "_fwd_s_tlast"}, fwd_s_tlast, 1'b0);
    chk1({nm, "_inv_s_tvalid"}, inv_s_tvalid, 1'b0);
    chk1({nm, "_inv_s_tlast"}, inv_s_tlast, 1'b0);
  endtask

  task automatic do_start(output int t);
    start = 1'b1;
    step();
    start = 1'b0;
    t = cyc;
    chk1("start_busy", busy, 1'b1);
    chk1("start_err_clear", err, 1'b0);
    chk1("start_fwd_cfg_tvalid", fwd_cfg_tvalid, 1'b1);
    chk1("start_inv_cfg_tvalid", inv_cfg_tvalid, 1'b1);
    chk("start_fwd_cfg_tdata", 32'(fwd_cfg_tdata), 32'h01);
    chk("start_inv_cfg_tdata", 32'(inv_cfg_tdata), 32'h00);
  endtask

  task automatic run_cfg(input int fl, input int il);
    int m;
    m = (fl > il) ? fl : il;
    for (int j = 0; j <= m; j++) begin
      fwd_cfg_tready = (j >= fl);
      inv_cfg_tready = (j >= il);
      @(negedge sys_clk);
      chk1("cfg_fwd_tvalid", fwd_cfg_tvalid, j <= fl);
      chk1("cfg_inv_tvalid", inv_cfg_tvalid, j <= il);
      chk1("cfg_no_load", fwd_s_tvalid, 1'b0);
      step();
    end
    fwd_cfg_tready = 1'b1;
    inv_cfg_tready = 1'b1;
  endtask

  task automatic run_load(input bit tog, input int abort_at, output bit aborted, output int kin);
    int idx, j;
    idx = 0;
    j = 0;
    aborted = 1'b0;
    kin = -1;
    while (idx < N) begin
      if (abort_at >= 0 && idx == abort_at) begin
        sys_rst = 1'b1;
        step();
        check_reset_vals("midrst");
        sys_rst = 1'b0;
        step();
        aborted = 1'b1;
        return;
      end
      fwd_s_tready = tog ? (j % 2 == 0) : 1'b1;
      adc_data = 10'($urandom);
      @(negedge sys_clk);
      chk1("load_tvalid", fwd_s_tvalid, 1'b1);
      chk1("load_tlast", fwd_s_tlast, idx == N - 1);
      chk("load_tdata", fwd_s_tdata, {22'b0, adc_data});
      if (fwd_s_tready) idx++;
      j++;
      step();
    end
    fwd_s_tready = 1'b1;
    kin = cyc;
    @(negedge sys_clk);
    chk1("load_end_tvalid", fwd_s_tvalid, 1'b0);
    chk1("load_end_tlast", fwd_s_tlast, 1'b0);
    step();
  endtask

  task automatic run_out(input int gap, input int nb, input int bad, output int klast, output int err_at);
    err_at = -1;
    repeat (gap) step();
    for (int i = 0; i < nb; i++) begin
      fwd_m_tvalid = 1'b1;
      fwd_m_tlast  = (bad >= 0) ? (i == bad) : (i % N == N - 1);
      if (cyc + 7 < MAXC) begin
        exp_v[cyc + 7] = 1'b1;
        exp_l[cyc + 7] = (i % N == N - 1);
      end
      if (i == bad) err_at = cyc + 1;
      @(negedge sys_clk);
      chk("coef_addr", 32'(coef_addr), 32'(i % N));
      step();
    end
    fwd_m_tvalid = 1'b0;
    fwd_m_tlast  = 1'b0;
    klast = cyc;
  endtask

  task automatic wait_done(input string nm, input int exp_cyc, input int err_cyc, input int stall_obs);
    for (int n = 0; n < 6000; n++) begin
      inv_s_tready = (cyc != stall_obs);
      @(negedge sys_clk);
      chk1({nm, "_err"}, err, (err_cyc >= 0) && (cyc >= err_cyc));
      if (done === 1'b1) begin
        chk({nm, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
        chk1({nm, "_busy_at_done"}, busy, 1'b0);
        step();
        inv_s_tready = 1'b1;
        @(negedge sys_clk);
        chk1({nm, "_done_single"}, done, 1'b0);
        step();
        return;
      end
      chk1({nm, "_busy"}, busy, 1'b1);
      step();
    end
    inv_s_tready = 1'b1;
    n_tot++;
    $display("FAIL %s_done_wait: no done pulse within budget, expected at cycle %0d", nm, exp_cyc);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, kin, klast, eat, v0, l0;
    bit ab;
    sys_rst = 1'b1; start = 1'b0; adc_data = '0;
    fwd_cfg_tready = 1'b1; inv_cfg_tready = 1'b1; fwd_s_tready = 1'b1;
    fwd_m_tvalid = 1'b0; fwd_m_tlast = 1'b0; inv_s_tready = 1'b1;
    repeat (3) step();
    check_reset_vals("por");
    sys_rst = 1'b0;
    chk_on = 1'b1;
    step();

    // Nominal frame
    do_start(t);
    run_cfg(0, 0);
    run_load(1'b0, -1, ab, kin);
    v0 = inv_v_cnt; l0 = inv_l_cnt;
    run_out(40, N, -1, klast, eat);
    wait_done("nom", klast + 8, -1, -1);
    chk("nom_inv_beats", 32'(inv_v_cnt - v0), 32'd1024);
    chk("nom_inv_lasts", 32'(inv_l_cnt - l0), 32'd1);

    // Config backpressure, throttled input, one refused product
    do_start(t);
    run_cfg(5, 2);
    run_load(1'b1, -1, ab, kin);
    v0 = inv_v_cnt; l0 = inv_l_cnt;
    run_out(40, N, -1, klast, eat);
    wait_done("bp", klast + 8, klast + 7, klast + 6);
    chk("bp_inv_beats", 32'(inv_v_cnt - v0), 32'd1024);
    chk("bp_inv_lasts", 32'(inv_l_cnt - l0), 32'd1);

    // Misframed output: tlast at bin 500
    do_start(t);
    run_cfg(0, 0);
    run_load(1'b0, -1, ab, kin);
    v0 = inv_v_cnt; l0 = inv_l_cnt;
    run_out(40, N, 500, klast, eat);
    wait_done("mis", klast + 8, eat, -1);
    chk("mis_inv_beats", 32'(inv_v_cnt - v0), 32'd1024);
    chk("mis_inv_lasts", 32'(inv_l_cnt - l0), 32'd1);
    chk1("mis_err_sticky", err, 1'b1);

    // Timeout: only 10 output beats; next start must clear err
    do_start(t);
    run_cfg(0, 0);
    run_load(1'b0, -1, ab, kin);
    v0 = inv_v_cnt; l0 = inv_l_cnt;
    run_out(40, 10, -1, klast, eat);
    wait_done("to", kin + TO + 1, kin + TO, -1);
    chk("to_inv_beats", 32'(inv_v_cnt - v0), 32'd10);
    chk("to_inv_lasts", 32'(inv_l_cnt - l0), 32'd0);

    // Reset at input beat 300, then a clean frame
    do_start(t);
    run_cfg(0, 0);
    run_load(1'b0, 300, ab, kin);
    do_start(t);
    run_cfg(0, 0);
    run_load(1'b0, -1, ab, kin);
    v0 = inv_v_cnt; l0 = inv_l_cnt;
    run_out(40, N, -1, klast, eat);
    wait_done("post_rst", klast + 8, -1, -1);
    chk("post_rst_inv_beats", 32'(inv_v_cnt - v0), 32'd1024);
    chk("post_rst_inv_lasts", 32'(inv_l_cnt - l0), 32'd1);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
